// File: rtl/fifo_pkg.sv
// fifo_pkg: shared mode encodings and default threshold offsets for fifo_param.
package fifo_pkg;
  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON = 1;
  localparam int AF_OFFSET = 2;
  localparam int AE_DEFAULT = 2;
endpackage

// File: rtl/fifo_status.sv
// fifo_status: decodes empty/full/almost flags purely from the registered word count.
module fifo_status #(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2
) (
  input  logic [ADDR_WIDTH:0] count,
  output logic                empty,
  output logic                full,
  output logic                almost_empty,
  output logic                almost_full
);
  localparam int RAM_DEPTH = 2**ADDR_WIDTH;
  assign empty = count == '0;
  assign full = int'(count) == RAM_DEPTH;
  assign almost_empty = int'(count) <= AE_THRESH;
  assign almost_full = int'(count) >= AF_THRESH;
endmodule

// File: rtl/fifo_param.sv
// fifo_param: single-clock FIFO with selectable standard or first-word-fall-through read,
// almost flags and sticky overflow/underflow errors.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT = FWFT_OFF,
  parameter int AF_THRESH = (2**ADDR_WIDTH) - AF_OFFSET,
  parameter int AE_THRESH = AE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int RAM_DEPTH = 2**ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_pointer, rd_pointer;
  logic push_ok, pop_ok;
  // a push into a full FIFO is still taken when a pop frees the slot that same edge
  assign push_ok = push && (!full || pop);
  assign pop_ok = pop && !empty;
  fifo_status #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .AF_THRESH(AF_THRESH),
    .AE_THRESH(AE_THRESH)
  ) u_status (
    .count(fifo_count),
    .empty(empty),
    .full(full),
    .almost_empty(almost_empty),
    .almost_full(almost_full)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_pointer <= '0;
      rd_pointer <= '0;
      fifo_count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_pointer <= wr_pointer + 1'b1;
      if (pop_ok) rd_pointer <= rd_pointer + 1'b1;
      if (push_ok != pop_ok) fifo_count <= push_ok ? fifo_count + 1'b1 : fifo_count - 1'b1;
      overflow <= !clr_err && (overflow || (push && full && !pop));
      underflow <= !clr_err && (underflow || (pop && empty));
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok && reset) mem[wr_pointer] <= data_in;
  end
  if (FWFT == FWFT_ON) begin : g_fwft
    assign data_out = mem[rd_pointer];
  end else begin : g_std
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) data_out <= '0;
      else if (pop_ok) data_out <= mem[rd_pointer];
    end
  end
endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed scoreboard bench for fifo_param in standard and FWFT modes.
module tb_fifo_param;
  logic clk = 0, reset = 0, push = 0, pop = 0, clr_err = 0, push1 = 0, pop1 = 0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out, data_out1;
  logic empty, full, almost_empty, almost_full, overflow, underflow;
  logic empty1, full1, almost_empty1, almost_full1, overflow1, underflow1;
  logic [4:0] fifo_count, fifo_count1;
  int n_chk = 0, n_pass = 0, mc = 0;
  logic [7:0] q[$];
  logic [7:0] m_do = '0;
  logic m_ov = 0, m_un = 0, rp, rr;

  fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in), .clr_err(clr_err),
    .data_out(data_out), .empty(empty), .full(full), .almost_empty(almost_empty),
    .almost_full(almost_full), .fifo_count(fifo_count), .overflow(overflow), .underflow(underflow)
  );
  fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1)) dut1 (
    .clk(clk), .reset(reset), .push(push1), .pop(pop1), .data_in(data_in), .clr_err(clr_err),
    .data_out(data_out1), .empty(empty1), .full(full1), .almost_empty(almost_empty1),
    .almost_full(almost_full1), .fifo_count(fifo_count1), .overflow(overflow1), .underflow(underflow1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, 64'(fifo_count), 64'(mc));
    chk({tag, ".empty"}, 64'(empty), 64'(mc == 0));
    chk({tag, ".full"}, 64'(full), 64'(mc == 16));
    chk({tag, ".almost_empty"}, 64'(almost_empty), 64'(mc <= 2));
    chk({tag, ".almost_full"}, 64'(almost_full), 64'(mc >= 14));
    chk({tag, ".data_out"}, 64'(data_out), 64'(m_do));
    chk({tag, ".overflow"}, 64'(overflow), 64'(m_ov));
    chk({tag, ".underflow"}, 64'(underflow), 64'(m_un));
  endtask

  task automatic cyc(input string tag, input logic p, input logic r, input logic [7:0] d, input logic c);
    push = p; pop = r; data_in = d; clr_err = c;
    @(posedge clk); #1;
    if (p && mc == 16 && !r) m_ov = 1;
    if (r && mc == 0) m_un = 1;
    if (c) begin m_ov = 0; m_un = 0; end
    if (r && mc > 0) m_do = q.pop_front();
    if (p && (mc < 16 || r)) q.push_back(d);
    mc = q.size();
    push = 0; pop = 0; clr_err = 0;
    check_all(tag);
  endtask

  initial begin
    #1;
    check_all("reset");
    chk("reset.fwft_empty", 64'(empty1), 64'd1);
    chk("reset.fwft_af", 64'(almost_full1), 64'd0);
    @(negedge clk) reset = 1;
    @(posedge clk); #1;
    for (int i = 1; i <= 16; i++) cyc("fill", 1, 0, 8'(i), 0);
    for (int i = 0; i < 16; i++) cyc("drain", 0, 1, 8'h00, 0);
    for (int i = 0; i < 16; i++) cyc("refill", 1, 0, 8'(8'h20 + i), 0);
    cyc("full_push_pop", 1, 1, 8'hAA, 0);
    cyc("overflow", 1, 0, 8'hBB, 0);
    cyc("clr_ov", 0, 0, 8'h00, 1);
    for (int i = 0; i < 16; i++) cyc("drain_aa", 0, 1, 8'h00, 0);
    chk("aa_last_out", 64'(data_out), 64'hAA);
    cyc("underflow", 0, 1, 8'h00, 0);
    cyc("empty_push_pop", 1, 1, 8'h55, 0);
    cyc("clr_un", 0, 0, 8'h00, 1);
    cyc("pop_55", 0, 1, 8'h00, 0);
    cyc("clr_prio", 0, 1, 8'h00, 1);
    for (int i = 0; i < 14; i++) cyc("ramp", 1, 0, 8'(8'h80 + i), 0);
    for (int i = 0; i < 40; i++) begin
      rp = (mc < 14) ? 1'($urandom_range(0, 1)) : 1'b0;
      rr = (mc > 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      cyc("wrap", rp, rr, 8'($urandom), 0);
    end
    while (mc > 0) cyc("wrap_drain", 0, 1, 8'h00, 0);
    push1 = 1; data_in = 8'h77;
    @(posedge clk); #1;
    push1 = 0;
    chk("fwft.empty", 64'(empty1), 64'd0);
    chk("fwft.data", 64'(data_out1), 64'h77);
    chk("fwft.count", 64'(fifo_count1), 64'd1);
    @(posedge clk); #1;
    chk("fwft.hold", 64'(data_out1), 64'h77);
    pop1 = 1;
    @(posedge clk); #1;
    pop1 = 0;
    chk("fwft.pop_empty", 64'(empty1), 64'd1);
    for (int i = 0; i < 9; i++) cyc("burst", 1, 0, 8'(8'hC0 + i), 0);
    push = 1; data_in = 8'hEE;
    #2 reset = 0;
    #1;
    q.delete(); mc = 0; m_do = '0; m_ov = 0; m_un = 0;
    check_all("async_reset");
    @(posedge clk); @(posedge clk); #1;
    chk("reset_hold.empty", 64'(empty), 64'd1);
    chk("reset_hold.count", 64'(fifo_count), 64'd0);
    @(negedge clk) begin reset = 1; push = 0; end
    @(posedge clk); #1;
    cyc("post_push", 1, 0, 8'h33, 0);
    cyc("post_pop", 0, 1, 8'h00, 0);
    chk("post_data", 64'(data_out), 64'h33);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
